// File: rtl/hazard_ctrl_pkg.sv
// Types and constants for the ID-stage hazard controller.
`include "definitions.sv"

package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN      = `HAZ_RUN,
    ST_MDU_BUSY = `HAZ_MDU_BUSY
  } haz_state_e;

  localparam logic [4:0] REG_ZERO = `REG_ZERO;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
  } pipe_ctrl_t;

endpackage

// File: rtl/definitions.sv
// Shared state encoding and register constants for the hazard controller.
`ifndef HAZ_DEFINITIONS_SV
`define HAZ_DEFINITIONS_SV

`define HAZ_RUN      1'b0
`define HAZ_MDU_BUSY 1'b1
`define REG_ZERO     5'd0

`endif

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the ID operands and a load in EX.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  output logic       luh
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_used && (id_rs2 == ex_rd);

  // x0 is never really written, so a load targeting it cannot create a hazard
  assign luh = ex_valid && ex_mem_read && (ex_rd != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage pipeline sequencing: load-use bubbles, EX redirects, MDU occupancy
// with a watchdog, and wrapping stall/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] WD_LAST = 16'(MDU_TIMEOUT - 1);

  haz_state_e       state_reg, state_next;
  logic [15:0]      wd_reg, wd_next;
  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  pipe_ctrl_t       ctrl;
  logic             luh;

  hazard_detect u_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .luh         (luh)
  );

  always_comb begin
    state_next   = state_reg;
    wd_next      = wd_reg;
    timeout_next = timeout_reg;
    ctrl         = '0;
    case (state_reg)
      ST_RUN: begin
        // a redirect squashes the ID instruction, so its load-use hazard is moot
        if (ex_redirect) begin
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (luh) begin
          ctrl.pc_stall    = 1'b1;
          ctrl.if_id_stall = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end
        if (ex_mdu_start) begin
          state_next = ST_MDU_BUSY;
          wd_next    = '0;
        end
      end
      ST_MDU_BUSY: begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.id_ex_stall = 1'b1;
        wd_next          = wd_reg + 16'd1;
        if (mdu_done) begin
          state_next = ST_RUN;
        end else if (wd_reg == WD_LAST) begin
          state_next   = ST_RUN;
          timeout_next = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      wd_reg        <= '0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wd_reg        <= wd_next;
      timeout_reg   <= timeout_next;
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(pc_stall);
      flush_cnt_reg <= flush_cnt_reg + CNT_W'(if_id_flush);
    end
  end

  // Controls are held inactive for the whole time reset is asserted
  assign pc_stall    = ctrl.pc_stall    && rst_n;
  assign if_id_stall = ctrl.if_id_stall && rst_n;
  assign if_id_flush = ctrl.if_id_flush && rst_n;
  assign id_ex_stall = ctrl.id_ex_stall && rst_n;
  assign id_ex_flush = ctrl.id_ex_flush && rst_n;
  assign mdu_timeout = timeout_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign flush_cnt   = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default-timeout instance plus an
// MDU_TIMEOUT=8 instance sharing the same stimulus.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_used, id_rs2_used, ex_valid, ex_mem_read;
  logic        ex_redirect, ex_mdu_start, mdu_done;

  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, mdu_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic        t8_pc_stall, t8_if_id_stall, t8_if_id_flush, t8_id_ex_stall, t8_id_ex_flush;
  logic        t8_mdu_timeout;
  logic [31:0] t8_stall_cnt, t8_flush_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .pc_stall(pc_stall),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
    .id_ex_flush(id_ex_flush), .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(32)) u_t8 (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_mdu_start(ex_mdu_start), .mdu_done(1'b0), .pc_stall(t8_pc_stall),
    .if_id_stall(t8_if_id_stall), .if_id_flush(t8_if_id_flush), .id_ex_stall(t8_id_ex_stall),
    .id_ex_flush(t8_id_ex_flush), .mdu_timeout(t8_mdu_timeout), .stall_cnt(t8_stall_cnt),
    .flush_cnt(t8_flush_cnt)
  );

  // redirect together with an MDU launch is an illegal input combination
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(ex_redirect && ex_mdu_start))
      else $error("FAIL illegal_redirect_mdu_start obs=1 exp=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; ex_mdu_start = 1'b0; mdu_done = 1'b0;
  endtask

  task automatic set_luh();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
  endtask

  initial begin
    int cnt;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_pc_stall", {31'd0, pc_stall}, 32'd0);
    chk("rst_id_ex_flush", {31'd0, id_ex_flush}, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_timeout", {31'd0, mdu_timeout}, 32'd0);
    rst_n = 1'b1;
    tick();

    // load-use on rs2: single bubble
    set_luh();
    #2;
    chk("luh_ctrl", {27'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}, 32'b11001);
    tick();
    clear_inputs();
    #2;
    chk("luh_released", {31'd0, pc_stall}, 32'd0);
    chk("luh_stall_cnt", stall_cnt, 32'd1);
    $display("luh: stall_cnt=%0d", stall_cnt);

    // load to x0, then unused operand: no hazard either way
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #2;
    chk("x0_ctrl", {27'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}, 32'd0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0;
    #2;
    chk("unused_ctrl", {27'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}, 32'd0);
    id_rs1_used = 1'b1;
    #1;
    chk("rs1_luh_pc_stall", {31'd0, pc_stall}, 32'd1);
    clear_inputs();
    tick();
    $display("x0/unused: stall_cnt=%0d", stall_cnt);

    // redirect beats load-use
    set_luh();
    ex_redirect = 1'b1;
    #2;
    chk("redir_ctrl", {27'd0, pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}, 32'b00101);
    tick();
    clear_inputs();
    #2;
    chk("redir_flush_cnt", flush_cnt, 32'd1);
    chk("redir_stall_cnt", stall_cnt, 32'd1);
    $display("redirect: flush_cnt=%0d stall_cnt=%0d", flush_cnt, stall_cnt);

    // MDU op: 11 busy cycles, done in the last one; redirect+luh ignored mid-op
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    ex_mdu_start = 1'b1;
    #2;
    chk("mdu_start_cycle", {31'd0, pc_stall}, 32'd0);
    tick();
    ex_mdu_start = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 11; i++) begin
      if (i == 5) begin set_luh(); ex_redirect = 1'b1; end
      if (i == 11) mdu_done = 1'b1;
      #2;
      if ({pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush} == 5'b11010) cnt++;
      tick();
      clear_inputs();
    end
    #2;
    chk("mdu_busy_cycles", cnt, 32'd11);
    chk("mdu_resumed", {31'd0, pc_stall}, 32'd0);
    chk("mdu_stall_cnt", stall_cnt, 32'd11);
    chk("mdu_no_timeout", {31'd0, mdu_timeout}, 32'd0);
    chk("mdu_flush_cnt", flush_cnt, 32'd0);
    $display("mdu: busy=%0d stall_cnt=%0d", cnt, stall_cnt);

    // watchdog expiry on the MDU_TIMEOUT=8 instance
    rst_n = 1'b0;
    #1;
    chk("t8_rst_timeout", {31'd0, t8_mdu_timeout}, 32'd0);
    rst_n = 1'b1;
    tick();
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (t8_pc_stall) cnt++;
      tick();
    end
    chk("t8_busy_cycles", cnt, 32'd8);
    chk("t8_timeout_held", {31'd0, t8_mdu_timeout}, 32'd1);
    chk("t8_stall_cnt", t8_stall_cnt, 32'd8);
    chk("dflt_still_busy", {31'd0, pc_stall}, 32'd1);
    $display("timeout: busy=%0d timeout=%0b", cnt, t8_mdu_timeout);

    // async reset mid-MDU
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", {31'd0, pc_stall}, 32'd0);
    chk("async_rst_cnt", stall_cnt, 32'd0);
    chk("t8_timeout_cleared", {31'd0, t8_mdu_timeout}, 32'd0);
    rst_n = 1'b1;
    tick();
    #2;
    chk("after_rst_run", {31'd0, pc_stall}, 32'd0);
    $display("async reset: pc_stall=%0b stall_cnt=%0d", pc_stall, stall_cnt);

    // counter wrap
    force u_dut.stall_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release u_dut.stall_cnt_reg;
    #1;
    chk("wrap_preload", stall_cnt, 32'hFFFF_FFFF);
    set_luh();
    tick();
    clear_inputs();
    #2;
    chk("wrap_to_zero", stall_cnt, 32'd0);
    $display("wrap: stall_cnt=%0d", stall_cnt);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
